mips_fetch_decode_pipe: RTL

- Parametrised instruction-fetch and IF/ID pipeline front end for the lab MIPS processor.
- Owns the PC register and drives the instruction-memory address.
- Registers the fetched word and PC+4 into an IF/ID stage, then splits the word into R/I/J fields.
- Computes the extended immediate, branch target and jump target in ID. Supports stall (hold) and redirect/flush from a later stage.

---
 rtl/mips_fetch_decode_pipe.sv | 95 +++++++++
 1 files changed

// File: rtl/mips_fetch_decode_pipe.sv
// Instruction-fetch PC register plus IF/ID pipeline stage for the lab MIPS core.
// Decodes R/I/J fields, extended immediate, branch and jump targets from the IF/ID registers.
module mips_fetch_decode_pipe #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     PC_STEP    = 4,
  parameter bit              ZEXT_LOGIC = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc4,
  output logic [31:0]     id_instr,
  output logic [5:0]      id_op,
  output logic [4:0]      id_rs,
  output logic [4:0]      id_rt,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_shamt,
  output logic [5:0]      id_funct,
  output logic [XLEN-1:0] id_imm_ext,
  output logic [XLEN-1:0] id_br_target,
  output logic [XLEN-1:0] id_jmp_target
);

  localparam int unsigned EXT_W = XLEN - 16;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_next_seq;
  logic            zext_sel;

  assign pc_next_seq = pc_q + XLEN'(PC_STEP);

  // redirect outranks stall for both the PC and the IF/ID stage
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_next_seq;
      pc4_d   = pc_next_seq;
      instr_d = imem_rdata;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = valid_q;
  assign id_pc4    = pc4_q;
  assign id_instr  = instr_q;
  assign id_op     = instr_q[31:26];
  assign id_rs     = instr_q[25:21];
  assign id_rt     = instr_q[20:16];
  assign id_rd     = instr_q[15:11];
  assign id_shamt  = instr_q[10:6];
  assign id_funct  = instr_q[5:0];

  // ANDI/ORI/XORI zero-extend when enabled; everything else (LUI included) sign-extends
  always_comb begin
    zext_sel = ZEXT_LOGIC && (instr_q[31:26] inside {6'h0C, 6'h0D, 6'h0E});
    if (zext_sel) id_imm_ext = {{EXT_W{1'b0}}, instr_q[15:0]};
    else          id_imm_ext = {{EXT_W{instr_q[15]}}, instr_q[15:0]};
  end

  assign id_br_target  = pc4_q + (id_imm_ext << 2);
  assign id_jmp_target = {pc4_q[XLEN-1:28], instr_q[25:0], 2'b00};

endmodule
